// File: rtl/i2c_target_pkg.sv
// Shared state encoding and protocol constants for the I2C register target.
package i2c_target_pkg;

  typedef enum logic [3:0] {
    IDLE, ADDR, ACK_ADDR, PTR, ACK_PTR, WRITE, ACK_WR, READ, MACK, IGNORE
  } state_t;

  localparam logic ACK_BIT   = 1'b0;
  localparam int   BIT_CNT_W = 4;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes raw SCL/SDA into the clock domain and detects SCL edges plus START/STOP.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync_r;
  logic [SYNC_STAGES-1:0] sda_sync_r;
  logic                   scl_prev_r;
  logic                   sda_prev_r;
  logic                   scl_s;

  assign scl_s = scl_sync_r[SYNC_STAGES-1];
  assign sda   = sda_sync_r[SYNC_STAGES-1];

  // Synchronizer chains idle high, matching a released bus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync_r <= {SYNC_STAGES{1'b1}};
      sda_sync_r <= {SYNC_STAGES{1'b1}};
      scl_prev_r <= 1'b1;
      sda_prev_r <= 1'b1;
    end else begin
      scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], scl_in};
      sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], sda_in};
      scl_prev_r <= scl_s;
      sda_prev_r <= sda;
    end
  end

  assign scl_rise  = scl_s & ~scl_prev_r;
  assign scl_fall  = ~scl_s & scl_prev_r;
  assign start_det = scl_s & scl_prev_r & sda_prev_r & ~sda;
  assign stop_det  = scl_s & scl_prev_r & ~sda_prev_r & sda;

endmodule

// File: rtl/i2c_register_target.sv
// I2C target emulating an accelerometer register file; pointer write, data write, repeated-start read.
// Optional macro I2C_TGT_AUTO_INC_EN enables pointer auto-increment on burst bytes.
module i2c_register_target
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h1D,
  parameter int         NUM_REGS    = 64,
  parameter int         SYNC_STAGES = 2,
  localparam int        PW          = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          scl_in,
  input  logic          sda_in,
  output logic          sda_oe,
  input  logic          ld_en,
  input  logic [PW-1:0] ld_addr,
  input  logic [7:0]    ld_data,
  output logic          wr_strobe,
  output logic [PW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          bus_active
);

  logic sda, scl_rise, scl_fall, start_det, stop_det;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
    .clk      (clk),
    .reset    (reset),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det)
  );

  state_t               state_r, state_n;
  logic [BIT_CNT_W-1:0] cnt_r, cnt_n;
  logic [7:0]           shift_r, shift_n;
  logic [PW-1:0]        ptr_r, ptr_n, ptr_inc_s;
  logic                 rw_r, rw_n;
  logic                 sda_oe_r, sda_oe_n;
  logic                 bus_active_r, bus_active_n;
  logic                 wr_strobe_r, wr_strobe_n;
  logic [PW-1:0]        wr_addr_r, wr_addr_n;
  logic [7:0]           wr_data_r, wr_data_n;
  logic                 reg_we_s, byte_done_s;
  logic [7:0]           byte_s;
  logic [7:0]           regs_r [NUM_REGS];

`ifdef I2C_TGT_AUTO_INC_EN
  assign ptr_inc_s = (ptr_r == PW'(NUM_REGS - 1)) ? {PW{1'b0}} : ptr_r + PW'(1);
`else
  assign ptr_inc_s = ptr_r;
`endif

  assign sda_oe     = sda_oe_r;
  assign bus_active = bus_active_r;
  assign wr_strobe  = wr_strobe_r;
  assign wr_addr    = wr_addr_r;
  assign wr_data    = wr_data_r;

  // Next-state and output decode; START/STOP override every state.
  always_comb begin
    state_n      = state_r;
    cnt_n        = cnt_r;
    shift_n      = shift_r;
    ptr_n        = ptr_r;
    rw_n         = rw_r;
    sda_oe_n     = sda_oe_r;
    bus_active_n = bus_active_r;
    wr_strobe_n  = 1'b0;
    wr_addr_n    = wr_addr_r;
    wr_data_n    = wr_data_r;
    reg_we_s     = 1'b0;
    byte_s       = {shift_r[6:0], sda};
    byte_done_s  = scl_rise && (cnt_r == 4'd7);

    if (stop_det) begin
      state_n      = IDLE;
      sda_oe_n     = 1'b0;
      bus_active_n = 1'b0;
      cnt_n        = 4'd0;
    end else if (start_det) begin
      state_n      = ADDR;
      sda_oe_n     = 1'b0;
      bus_active_n = 1'b1;
      cnt_n        = 4'd0;
    end else begin
      case (state_r)
        ADDR, PTR, WRITE: begin
          if (scl_rise) begin
            shift_n = byte_s;
            cnt_n   = byte_done_s ? 4'd0 : cnt_r + 4'd1;
          end else begin
            shift_n = shift_r;
          end
          if (byte_done_s && state_r == ADDR) begin
            rw_n    = byte_s[0];
            state_n = (byte_s[7:1] == DEV_ADDR) ? ACK_ADDR : IGNORE;
          end else if (byte_done_s && state_r == PTR) begin
            ptr_n   = PW'({24'd0, byte_s} % NUM_REGS);
            state_n = ACK_PTR;
          end else if (byte_done_s) begin
            reg_we_s    = 1'b1;
            wr_strobe_n = 1'b1;
            wr_addr_n   = ptr_r;
            wr_data_n   = byte_s;
            state_n     = ACK_WR;
          end else begin
            state_n = state_r;
          end
        end
        ACK_ADDR, ACK_PTR, ACK_WR: begin
          // First fall drives the ACK, second fall ends the ninth clock.
          if (scl_fall && cnt_r == 4'd0) begin
            sda_oe_n = ~ACK_BIT;
            cnt_n    = 4'd1;
          end else if (scl_fall) begin
            sda_oe_n = 1'b0;
            cnt_n    = 4'd0;
            case (state_r)
              ACK_ADDR: begin
                if (rw_r) begin
                  state_n  = READ;
                  shift_n  = {regs_r[ptr_r][6:0], 1'b0};
                  sda_oe_n = ~regs_r[ptr_r][7];
                  cnt_n    = 4'd1;
                end else begin
                  state_n = PTR;
                end
              end
              ACK_PTR: state_n = WRITE;
              default: begin
                state_n = WRITE;
                ptr_n   = ptr_inc_s;
              end
            endcase
          end else begin
            cnt_n = cnt_r;
          end
        end
        READ: begin
          if (scl_fall && cnt_r == 4'd8) begin
            sda_oe_n = 1'b0;
            cnt_n    = 4'd0;
            state_n  = MACK;
          end else if (scl_fall) begin
            sda_oe_n = ~shift_r[7];
            shift_n  = {shift_r[6:0], 1'b0};
            cnt_n    = cnt_r + 4'd1;
          end else begin
            cnt_n = cnt_r;
          end
        end
        MACK: begin
          if (scl_rise && sda == ACK_BIT) begin
            ptr_n   = ptr_inc_s;
            shift_n = regs_r[ptr_inc_s];
            state_n = READ;
          end else if (scl_rise) begin
            state_n = IGNORE;
          end else begin
            state_n = state_r;
          end
        end
        IDLE, IGNORE: state_n = state_r;
        default:      state_n = IDLE;
      endcase
    end
  end

  // Protocol state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      cnt_r        <= 4'd0;
      shift_r      <= 8'h00;
      ptr_r        <= {PW{1'b0}};
      rw_r         <= 1'b0;
      sda_oe_r     <= 1'b0;
      bus_active_r <= 1'b0;
      wr_strobe_r  <= 1'b0;
      wr_addr_r    <= {PW{1'b0}};
      wr_data_r    <= 8'h00;
    end else begin
      state_r      <= state_n;
      cnt_r        <= cnt_n;
      shift_r      <= shift_n;
      ptr_r        <= ptr_n;
      rw_r         <= rw_n;
      sda_oe_r     <= sda_oe_n;
      bus_active_r <= bus_active_n;
      wr_strobe_r  <= wr_strobe_n;
      wr_addr_r    <= wr_addr_n;
      wr_data_r    <= wr_data_n;
    end
  end

  // Register file; a bus write overrides a same-cycle host load to the same entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_r[i] <= 8'h00;
    end else begin
      if (ld_en) regs_r[ld_addr] <= ld_data;
      if (reg_we_s) regs_r[ptr_r] <= byte_s;
    end
  end

endmodule

// File: tb/tb_i2c_register_target.sv
// Directed bench for i2c_register_target: a bit-banged master drives the bus, expectations are hand-computed.
module tb_i2c_register_target;
  import i2c_target_pkg::*;

  localparam int Q = 12;

  logic       clk = 1'b0, reset = 1'b1, scl = 1'b1, sda_m = 1'b1;
  logic       ld_en = 1'b0;
  logic [5:0] ld_addr = 6'd0;
  logic [7:0] ld_data = 8'h00;
  logic       sda_oe, wr_strobe, bus_active;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;
  wire        sda_line = sda_m & ~sda_oe;

  int         tests_run = 0, tests_failed = 0;
  int         strobe_cnt = 0, oe_cnt = 0;
  logic [5:0] last_addr = 6'd0;
  logic [7:0] last_data = 8'h00;

  always #5 clk = ~clk;

  i2c_register_target dut (
    .clk(clk), .reset(reset), .scl_in(scl), .sda_in(sda_line), .sda_oe(sda_oe),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data), .bus_active(bus_active)
  );

  always @(negedge clk) begin
    if (wr_strobe) begin
      strobe_cnt = strobe_cnt + 1;
      last_addr  = wr_addr;
      last_data  = wr_data;
    end
    if (sda_oe) oe_cnt = oe_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic qwait();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; qwait(); scl = 1'b1; qwait(); sda_m = 1'b0; qwait(); scl = 1'b0; qwait();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; qwait(); scl = 1'b1; qwait(); sda_m = 1'b1; qwait();
  endtask

  task automatic bus_bit(input logic b, output logic s);
    sda_m = b; qwait(); scl = 1'b1; qwait(); s = sda_line; qwait(); scl = 1'b0; qwait();
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(d[i], s);
    bus_bit(1'b1, ack);
  endtask

  task automatic rd_byte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, s);
      d[i] = s;
    end
    bus_bit(mack, s);
  endtask

  // Holds a host load active until the bus write lands so both hit the same clock edge.
  task automatic wr_byte_collide(input logic [7:0] d, input logic [5:0] a, input logic [7:0] hd,
                                 output logic ack);
    logic s, seen;
    for (int i = 7; i >= 1; i--) bus_bit(d[i], s);
    sda_m = d[0]; qwait();
    ld_addr = a; ld_data = hd; ld_en = 1'b1;
    scl = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 4 * Q && !seen; k++) begin
      @(negedge clk);
      if (wr_strobe) seen = 1'b1;
    end
    ld_en = 1'b0;
    check("collide_strobe_seen", seen, 1);
    qwait(); scl = 1'b0; qwait();
    bus_bit(1'b1, ack);
  endtask

  task automatic host_load(input logic [5:0] a, input logic [7:0] d);
    ld_addr = a; ld_data = d; ld_en = 1'b1;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic read_reg(input logic [5:0] a, output logic [7:0] d);
    logic ack;
    bus_start(); wr_byte(8'h3A, ack); wr_byte({2'b00, a}, ack);
    bus_start(); wr_byte(8'h3B, ack); rd_byte(1'b1, d); bus_stop();
  endtask

  initial begin
    logic       ack, s;
    logic [7:0] d;
    int         sc, oc;

    repeat (5) @(negedge clk);
    check("rst_sda_oe_in_reset", sda_oe, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_bus_active", bus_active, 0);
    check("rst_wr_strobe", wr_strobe, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_state", dut.state_r, IDLE);

    // Single register write.
    sc = strobe_cnt;
    bus_start();
    check("wr_bus_active_hi", bus_active, 1);
    wr_byte(8'h3A, ack); check("wr_ack_addr", ack, 0);
    wr_byte(8'h0E, ack); check("wr_ack_ptr", ack, 0);
    wr_byte(8'h10, ack); check("wr_ack_data", ack, 0);
    bus_stop();
    check("wr_bus_active_lo", bus_active, 0);
    check("wr_strobe_count", strobe_cnt - sc, 1);
    check("wr_strobe_addr", last_addr, 6'h0E);
    check("wr_strobe_data", last_data, 8'h10);
    read_reg(6'h0E, d);
    check("wr_readback", d, 8'h10);

    // Pointer write then repeated-start burst read.
    host_load(6'h01, 8'hA5);
    host_load(6'h02, 8'h3C);
    bus_start(); wr_byte(8'h3A, ack); wr_byte(8'h01, ack);
    bus_start(); wr_byte(8'h3B, ack); check("rd_ack_addr", ack, 0);
    rd_byte(1'b0, d); check("rd_byte0", d, 8'hA5);
    rd_byte(1'b1, d);
`ifdef I2C_TGT_AUTO_INC_EN
    check("rd_byte1", d, 8'h3C);
`else
    check("rd_byte1", d, 8'hA5);
`endif
    bus_stop();

    // Foreign address: never drives SDA, never writes.
    sc = strobe_cnt; oc = oe_cnt;
    bus_start();
    wr_byte(8'h40, ack); check("mis_addr_nack", ack, 1);
    wr_byte(8'h55, ack); check("mis_data_nack", ack, 1);
    bus_stop();
    check("mis_sda_oe", oe_cnt - oc, 0);
    check("mis_strobe", strobe_cnt - sc, 0);

    // Pointer wrap at the top of the register file.
    bus_start(); wr_byte(8'h3A, ack); wr_byte(8'h3F, ack);
    wr_byte(8'h11, ack); wr_byte(8'h22, ack); bus_stop();
    read_reg(6'h3F, d);
`ifdef I2C_TGT_AUTO_INC_EN
    check("wrap_last_addr", last_addr, 6'h00);
    check("wrap_reg3f", d, 8'h11);
    read_reg(6'h00, d);
    check("wrap_reg00", d, 8'h22);
`else
    check("wrap_last_addr", last_addr, 6'h3F);
    check("wrap_reg3f", d, 8'h22);
    read_reg(6'h00, d);
    check("wrap_reg00", d, 8'h00);
`endif

    // Host load and bus write to the same register in the same cycle.
    sc = strobe_cnt;
    bus_start(); wr_byte(8'h3A, ack); wr_byte(8'h05, ack);
    wr_byte_collide(8'h99, 6'h05, 8'h77, ack);
    check("collide_ack", ack, 0);
    bus_stop();
    check("collide_strobe_count", strobe_cnt - sc, 1);
    check("collide_strobe_data", last_data, 8'h99);
    read_reg(6'h05, d);
    check("collide_reg05", d, 8'h99);

    // STOP after four data bits aborts the byte.
    sc = strobe_cnt;
    bus_start(); wr_byte(8'h3A, ack); wr_byte(8'h05, ack);
    bus_bit(1'b0, s); bus_bit(1'b0, s); bus_bit(1'b0, s); bus_bit(1'b1, s);
    bus_stop();
    check("stopmid_strobe", strobe_cnt - sc, 0);
    check("stopmid_state", dut.state_r, IDLE);
    check("stopmid_bus_active", bus_active, 0);
    read_reg(6'h05, d);
    check("stopmid_reg05", d, 8'h99);

    // Reset while the target drives a 0 data bit.
    host_load(6'h20, 8'h0F);
    bus_start(); wr_byte(8'h3A, ack); wr_byte(8'h20, ack);
    bus_start(); wr_byte(8'h3B, ack);
    check("rstmid_driving", sda_oe, 1);
    #1 reset = 1'b1;
    #1 check("rstmid_release", sda_oe, 0);
    scl = 1'b1; sda_m = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    host_load(6'h00, 8'h5A);
    host_load(6'h20, 8'h66);
    bus_start(); wr_byte(8'h3B, ack); check("post_rst_ack", ack, 0);
    rd_byte(1'b1, d); check("post_rst_ptr0", d, 8'h5A);
    bus_stop();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
